// File: rtl/draw_pkg.sv
// Shared types and constants for the text overlay pipeline stage.
// Used by draw_text_overlay, its reveal sequencer and its interface.
// Optional macro DRAW_TEXT_BG_EN (see draw_text_overlay.sv) adds a solid text box.
package draw_pkg;

    // Glyph cell geometry in pixels.
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    // 4:4:4 pixel colour.
    typedef logic [11:0] rgb_t;

    // Timing bundle carried alongside each pixel through the delay line.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;

    // Reveal sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        DONE   = 2'd2
    } reveal_state_e;

    // Observable snapshot of the reveal sequencer.
    typedef struct packed {
        reveal_state_e state;
        logic [8:0]    reveal_cnt;
        logic [15:0]   frame_cnt;
    } reveal_dbg_t;

endpackage

// File: rtl/draw_text_overlay_if.sv
// Port bundle of the text overlay stage: pixel stream in/out, text and font
// ROM address/data, the reveal control and a debug view of the sequencer.
//
// Stream contract: one pixel per clock with no back-pressure. Every *_in
// signal is a pixel accepted on each rising clk edge; the matching *_out
// pixel appears exactly three clocks later. char_xy and font_addr are
// combinational requests; the ROMs answer on char_code / font_data one clock
// after the request. start is a single-cycle pulse.
interface draw_text_overlay_if;
    import draw_pkg::*;

    logic        start;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    rgb_t        rgb_in;

    logic [7:0]  char_xy;
    logic [6:0]  char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_data;

    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    rgb_t        rgb_out;
    logic        reveal_done;
    reveal_dbg_t reveal_dbg;

    // Upstream / ROM side: produces pixels and ROM data, consumes results.
    modport master (
        output start, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in,
               vblnk_in, rgb_in, char_code, font_data,
        input  char_xy, font_addr, hcount_out, vcount_out, hsync_out,
               vsync_out, hblnk_out, vblnk_out, rgb_out, reveal_done,
               reveal_dbg
    );

    // Overlay stage side.
    modport slave (
        input  start, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in,
               vblnk_in, rgb_in, char_code, font_data,
        output char_xy, font_addr, hcount_out, vcount_out, hsync_out,
               vsync_out, hblnk_out, vblnk_out, rgb_out, reveal_done,
               reveal_dbg
    );

endinterface

// File: rtl/text_reveal_fsm.sv
// Typewriter reveal sequencer: after start, one more character becomes
// visible every REVEAL_FRAMES rising edges of vsync, until all are shown.
module text_reveal_fsm
    import draw_pkg::*;
#(
    parameter int TOTAL_CHARS   = 16,
    parameter int REVEAL_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        vsync_in,
    output logic [8:0]  reveal_cnt,
    output logic        reveal_done,
    output reveal_dbg_t dbg
);

    localparam int             FW         = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [FW-1:0]  FRAME_LAST = FW'(REVEAL_FRAMES - 1);
    localparam logic [8:0]     TOTAL      = 9'(TOTAL_CHARS);

    reveal_state_e state_q, state_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          done_q, done_d;
    logic          vsync_prev_q, vsync_prev_d;
    logic          tick;

    // Next-state logic; start overrides everything, including a same-cycle tick.
    always_comb begin
        tick         = vsync_in & ~vsync_prev_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        done_d       = done_q;
        vsync_prev_d = vsync_in;
        if (start) begin
            state_d = REVEAL;
            cnt_d   = '0;
            frame_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    frame_d = '0;
                    done_d  = 1'b0;
                end
                REVEAL: begin
                    if (tick) begin
                        if (frame_q == FRAME_LAST) begin
                            frame_d = '0;
                            cnt_d   = cnt_q + 9'd1;
                            if (cnt_q + 9'd1 >= TOTAL) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    frame_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_q      <= '0;
            done_q       <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            done_q       <= done_d;
            vsync_prev_q <= vsync_prev_d;
        end
    end

    assign reveal_cnt  = cnt_q;
    assign reveal_done = done_q;
    assign dbg         = '{state: state_q, reveal_cnt: cnt_q, frame_cnt: 16'(frame_q)};

endmodule

// File: rtl/draw_text_overlay.sv
// Text overlay stage: looks up characters in a text ROM, fetches glyph rows
// from a font ROM and paints revealed glyph pixels over the incoming stream.
// Three-clock pipeline; timing signals are delayed to match.
// Optional macro DRAW_TEXT_BG_EN: unlit pixels inside the text area are
// painted TEXT_BG_RGB instead of passing the background through.
module draw_text_overlay
    import draw_pkg::*;
#(
    parameter logic [10:0] TEXT_X        = 11'd256,
    parameter logic [10:0] TEXT_Y        = 11'd200,
    parameter int          TEXT_COLS     = 16,
    parameter int          TEXT_ROWS     = 1,
    parameter rgb_t        TEXT_RGB      = 12'hfff,
`ifdef DRAW_TEXT_BG_EN
    parameter rgb_t        TEXT_BG_RGB   = 12'h000,
`endif
    parameter int          REVEAL_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    draw_text_overlay_if.slave bus
);

    localparam logic [10:0] AREA_W = 11'(CHAR_W * TEXT_COLS);
    localparam logic [10:0] AREA_H = 11'(CHAR_H * TEXT_ROWS);
    localparam logic [7:0]  COLS8  = 8'(TEXT_COLS);

    // Stage 0 helpers (combinational from the current pixel).
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_area;
    vga_timing_t timing_in;

    // Stage 1 registers.
    logic        s1_in_area_q, s1_in_area_d;
    logic [3:0]  s1_line_q, s1_line_d;
    logic [2:0]  s1_bit_q, s1_bit_d;
    logic [7:0]  s1_idx_q, s1_idx_d;
    vga_timing_t s1_timing_q, s1_timing_d;
    rgb_t        s1_rgb_q, s1_rgb_d;

    // Stage 2 registers.
    logic        s2_in_area_q, s2_in_area_d;
    logic [2:0]  s2_bit_q, s2_bit_d;
    logic [7:0]  s2_idx_q, s2_idx_d;
    vga_timing_t s2_timing_q, s2_timing_d;
    rgb_t        s2_rgb_q, s2_rgb_d;

    // Stage 3 (output) registers.
    vga_timing_t s3_timing_q, s3_timing_d;
    rgb_t        rgb_out_q, rgb_out_d;

    logic [8:0]  reveal_cnt;
    logic        glyph_on;
    logic        blanked;

    assign timing_in = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                         hsync:  bus.hsync_in,  vsync:  bus.vsync_in,
                         hblnk:  bus.hblnk_in,  vblnk:  bus.vblnk_in};

    text_reveal_fsm #(
        .TOTAL_CHARS  (TEXT_COLS * TEXT_ROWS),
        .REVEAL_FRAMES(REVEAL_FRAMES)
    ) u_reveal (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (bus.start),
        .vsync_in   (bus.vsync_in),
        .reveal_cnt (reveal_cnt),
        .reveal_done(bus.reveal_done),
        .dbg        (bus.reveal_dbg)
    );

    // Area test, text ROM address and stage-1 next values.
    // The >= checks come first so pixels left of / above the box never wrap in.
    always_comb begin
        dx      = bus.hcount_in - TEXT_X;
        dy      = bus.vcount_in - TEXT_Y;
        in_area = (bus.hcount_in >= TEXT_X) && (dx < AREA_W) &&
                  (bus.vcount_in >= TEXT_Y) && (dy < AREA_H);

        bus.char_xy  = in_area ? {dy[7:4], dx[6:3]} : 8'h00;

        s1_in_area_d = in_area;
        s1_line_d    = dy[3:0];
        s1_bit_d     = dx[2:0];
        s1_idx_d     = in_area ? (({4'd0, dy[7:4]} * COLS8) + {4'd0, dx[6:3]}) : 8'h00;
        s1_timing_d  = timing_in;
        s1_rgb_d     = bus.rgb_in;
    end

    // Font ROM address from the returned character code and stage-1 glyph line.
    always_comb begin
        bus.font_addr = {bus.char_code, s1_line_q};
        s2_in_area_d  = s1_in_area_q;
        s2_bit_d      = s1_bit_q;
        s2_idx_d      = s1_idx_q;
        s2_timing_d   = s1_timing_q;
        s2_rgb_d      = s1_rgb_q;
    end

    // Pixel compositing: blanking forces black, revealed lit glyph bits win.
    always_comb begin
        glyph_on    = s2_in_area_q && bus.font_data[3'd7 - s2_bit_q] &&
                      ({1'b0, s2_idx_q} < reveal_cnt);
        blanked     = s2_timing_q.hblnk | s2_timing_q.vblnk;
        s3_timing_d = s2_timing_q;
        if (blanked) begin
            rgb_out_d = 12'h000;
        end else if (glyph_on) begin
            rgb_out_d = TEXT_RGB;
`ifdef DRAW_TEXT_BG_EN
        end else if (s2_in_area_q) begin
            rgb_out_d = TEXT_BG_RGB;
`endif
        end else begin
            rgb_out_d = s2_rgb_q;
        end
    end

    // Pipeline registers for all three stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_area_q <= 1'b0;
            s1_line_q    <= '0;
            s1_bit_q     <= '0;
            s1_idx_q     <= '0;
            s1_timing_q  <= '0;
            s1_rgb_q     <= '0;
            s2_in_area_q <= 1'b0;
            s2_bit_q     <= '0;
            s2_idx_q     <= '0;
            s2_timing_q  <= '0;
            s2_rgb_q     <= '0;
            s3_timing_q  <= '0;
            rgb_out_q    <= '0;
        end else begin
            s1_in_area_q <= s1_in_area_d;
            s1_line_q    <= s1_line_d;
            s1_bit_q     <= s1_bit_d;
            s1_idx_q     <= s1_idx_d;
            s1_timing_q  <= s1_timing_d;
            s1_rgb_q     <= s1_rgb_d;
            s2_in_area_q <= s2_in_area_d;
            s2_bit_q     <= s2_bit_d;
            s2_idx_q     <= s2_idx_d;
            s2_timing_q  <= s2_timing_d;
            s2_rgb_q     <= s2_rgb_d;
            s3_timing_q  <= s3_timing_d;
            rgb_out_q    <= rgb_out_d;
        end
    end

    assign bus.hcount_out = s3_timing_q.hcount;
    assign bus.vcount_out = s3_timing_q.vcount;
    assign bus.hsync_out  = s3_timing_q.hsync;
    assign bus.vsync_out  = s3_timing_q.vsync;
    assign bus.hblnk_out  = s3_timing_q.hblnk;
    assign bus.vblnk_out  = s3_timing_q.vblnk;
    assign bus.rgb_out    = rgb_out_q;

endmodule
